// File: rtl/ifmap_row_scheduler.sv
// ifmap_row_scheduler
// Sequences IFMAP row reads for the partial-sum PEs: a broadcast phase that
// hands every PE its first row, then a round-robin serve phase in which each
// PE pulls its remaining rows on request. Rows are packed into router packets
// {dest[32:29], opcode[28:25], data[24:0]}.
// Optional feature macro: IFMAP_SCHED_STATS_EN adds stat_pkts / stat_stalls.
module ifmap_row_scheduler #(
    parameter int NUM_PE       = 5,
    parameter int IFMAP_SIZE   = 25,
    parameter int PE_BASE_ID   = 5,
    parameter int OP_PPE_INPUT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_valid,
    input  logic                    start_ts,
    output logic                    start_ready,
    input  logic [NUM_PE-1:0]       req_valid,
    output logic [NUM_PE-1:0]       req_ready,
    output logic                    mem_rd_valid,
    input  logic                    mem_rd_ready,
    output logic                    mem_rd_ts,
    output logic [4:0]              mem_rd_row,
    input  logic                    mem_rdata_valid,
    input  logic [IFMAP_SIZE-1:0]   mem_rdata,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic [IFMAP_SIZE+7:0]   pkt_data,
    output logic                    busy,
    output logic [NUM_PE-1:0]       exhausted,
    output logic                    err_overrun
`ifdef IFMAP_SCHED_STATS_EN
    ,
    output logic [15:0]             stat_pkts,
    output logic [15:0]             stat_stalls
`endif
);

    localparam int IDX_W = $clog2(NUM_PE);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        B_RD   = 3'd1,
        B_WAIT = 3'd2,
        B_SEND = 3'd3,
        SERVE  = 3'd4,
        RD     = 3'd5,
        WAIT   = 3'd6,
        SEND   = 3'd7
    } state_t;

    state_t                  state_q, state_d;
    logic                    ts_q, ts_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]        bcast_idx_q, bcast_idx_d;
    logic [IDX_W-1:0]        gnt_q, gnt_d;
    logic [5:0]              ptr_q [NUM_PE];
    logic [5:0]              ptr_d [NUM_PE];
    logic [4:0]              mem_rd_row_q, mem_rd_row_d;
    logic [IFMAP_SIZE+7:0]   pkt_data_q, pkt_data_d;
    logic [NUM_PE-1:0]       req_ready_q, req_ready_d;
    logic                    err_overrun_q, err_overrun_d;
`ifdef IFMAP_SCHED_STATS_EN
    logic [15:0]             stat_pkts_q, stat_pkts_d;
    logic [15:0]             stat_stalls_q, stat_stalls_d;
`endif

    logic                    start_hs_s;
    logic                    pkt_valid_s;
    logic                    arb_found_s;
    logic [IDX_W-1:0]        arb_idx_s;
    logic [IDX_W:0]          cand_s;

    assign start_ready  = (state_q == IDLE) || (state_q == SERVE);
    assign start_hs_s   = start_valid && start_ready;
    assign pkt_valid_s  = (state_q == B_SEND) || (state_q == SEND);
    assign pkt_valid    = pkt_valid_s;
    assign mem_rd_valid = (state_q == B_RD) || (state_q == RD);
    assign mem_rd_ts    = ts_q;
    assign mem_rd_row   = mem_rd_row_q;
    assign pkt_data     = pkt_data_q;
    assign req_ready    = req_ready_q;
    assign err_overrun  = err_overrun_q;
    assign busy         = (state_q != IDLE) && (state_q != SERVE);
`ifdef IFMAP_SCHED_STATS_EN
    assign stat_pkts    = stat_pkts_q;
    assign stat_stalls  = stat_stalls_q;
`endif

    // A PE is exhausted once its row pointer has passed the last row.
    always_comb begin
        exhausted = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            exhausted[k] = (ptr_q[k] >= 6'(IFMAP_SIZE));
        end
    end

    // Round-robin search: first valid request at or after rr_ptr, wrapping.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = '0;
        cand_s      = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            cand_s = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            cand_s = (cand_s >= (IDX_W+1)'(NUM_PE)) ? (cand_s - (IDX_W+1)'(NUM_PE)) : cand_s;
            if (!arb_found_s && req_valid[cand_s[IDX_W-1:0]]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_d       = state_q;
        ts_d          = ts_q;
        rr_ptr_d      = rr_ptr_q;
        bcast_idx_d   = bcast_idx_q;
        gnt_d         = gnt_q;
        ptr_d         = ptr_q;
        mem_rd_row_d  = mem_rd_row_q;
        pkt_data_d    = pkt_data_q;
        req_ready_d   = '0;
        err_overrun_d = 1'b0;

        if (start_hs_s) begin
            // A start wins over any same-cycle request in SERVE.
            ts_d         = start_ts;
            bcast_idx_d  = '0;
            mem_rd_row_d = 5'd0;
            state_d      = B_RD;
            for (int k = 0; k < NUM_PE; k++) begin
                ptr_d[k] = 6'(k);
            end
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                B_RD: state_d = mem_rd_ready ? B_WAIT : B_RD;
                B_WAIT: begin
                    if (mem_rdata_valid) begin
                        pkt_data_d = {4'(PE_BASE_ID) + 4'(bcast_idx_q), 4'(OP_PPE_INPUT), mem_rdata};
                        state_d    = B_SEND;
                    end else begin
                        state_d    = B_WAIT;
                    end
                end
                B_SEND: begin
                    if (pkt_ready) begin
                        ptr_d[bcast_idx_q] = ptr_q[bcast_idx_q] + 6'd5;
                        if (bcast_idx_q == IDX_W'(NUM_PE - 1)) begin
                            state_d = SERVE;
                        end else begin
                            bcast_idx_d  = bcast_idx_q + IDX_W'(1);
                            mem_rd_row_d = 5'(bcast_idx_q) + 5'd1;
                            state_d      = B_RD;
                        end
                    end else begin
                        state_d = B_SEND;
                    end
                end
                SERVE: begin
                    // The ack is registered; skip arbitration while one is still showing
                    // so a PE that has not yet seen its ack is not granted twice.
                    if (arb_found_s && (req_ready_q == '0)) begin
                        req_ready_d[arb_idx_s] = 1'b1;
                        rr_ptr_d = (arb_idx_s == IDX_W'(NUM_PE - 1)) ? '0 : (arb_idx_s + IDX_W'(1));
                        if (ptr_q[arb_idx_s] >= 6'(IFMAP_SIZE)) begin
                            err_overrun_d = 1'b1;
                        end else begin
                            gnt_d        = arb_idx_s;
                            mem_rd_row_d = ptr_q[arb_idx_s][4:0];
                            state_d      = RD;
                        end
                    end else begin
                        state_d = SERVE;
                    end
                end
                RD: state_d = mem_rd_ready ? WAIT : RD;
                WAIT: begin
                    if (mem_rdata_valid) begin
                        pkt_data_d = {4'(PE_BASE_ID) + 4'(gnt_q), 4'(OP_PPE_INPUT), mem_rdata};
                        state_d    = SEND;
                    end else begin
                        state_d    = WAIT;
                    end
                end
                SEND: begin
                    if (pkt_ready) begin
                        ptr_d[gnt_q] = ptr_q[gnt_q] + 6'd5;
                        state_d      = SERVE;
                    end else begin
                        state_d      = SEND;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef IFMAP_SCHED_STATS_EN
    // Saturating packet and stall counters, cleared by a start.
    always_comb begin
        stat_pkts_d   = stat_pkts_q;
        stat_stalls_d = stat_stalls_q;
        if (start_hs_s) begin
            stat_pkts_d   = 16'd0;
            stat_stalls_d = 16'd0;
        end else begin
            if (pkt_valid_s && pkt_ready && (stat_pkts_q != 16'hFFFF)) begin
                stat_pkts_d = stat_pkts_q + 16'd1;
            end else begin
                stat_pkts_d = stat_pkts_q;
            end
            if (pkt_valid_s && !pkt_ready && (stat_stalls_q != 16'hFFFF)) begin
                stat_stalls_d = stat_stalls_q + 16'd1;
            end else begin
                stat_stalls_d = stat_stalls_q;
            end
        end
    end
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ts_q          <= 1'b0;
            rr_ptr_q      <= '0;
            bcast_idx_q   <= '0;
            gnt_q         <= '0;
            ptr_q         <= '{default: 6'd0};
            mem_rd_row_q  <= 5'd0;
            pkt_data_q    <= '0;
            req_ready_q   <= '0;
            err_overrun_q <= 1'b0;
`ifdef IFMAP_SCHED_STATS_EN
            stat_pkts_q   <= 16'd0;
            stat_stalls_q <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            ts_q          <= ts_d;
            rr_ptr_q      <= rr_ptr_d;
            bcast_idx_q   <= bcast_idx_d;
            gnt_q         <= gnt_d;
            ptr_q         <= ptr_d;
            mem_rd_row_q  <= mem_rd_row_d;
            pkt_data_q    <= pkt_data_d;
            req_ready_q   <= req_ready_d;
            err_overrun_q <= err_overrun_d;
`ifdef IFMAP_SCHED_STATS_EN
            stat_pkts_q   <= stat_pkts_d;
            stat_stalls_q <= stat_stalls_d;
`endif
        end
    end

endmodule

// File: tb/tb_ifmap_row_scheduler.sv
// Directed bench for ifmap_row_scheduler. A small memory model answers each
// accepted read after mem_lat cycles with data {ts, 19'b0, row}.
module tb_ifmap_row_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ts = 1'b0;
    logic        start_ready;
    logic [4:0]  req_valid = 5'd0;
    logic [4:0]  req_ready;
    logic        mem_rd_valid;
    logic        mem_rd_ready = 1'b1;
    logic        mem_rd_ts;
    logic [4:0]  mem_rd_row;
    logic        mem_rdata_valid = 1'b0;
    logic [24:0] mem_rdata = 25'd0;
    logic        pkt_valid;
    logic        pkt_ready = 1'b1;
    logic [32:0] pkt_data;
    logic        busy;
    logic [4:0]  exhausted;
    logic        err_overrun;
`ifdef IFMAP_SCHED_STATS_EN
    logic [15:0] stat_pkts;
    logic [15:0] stat_stalls;
`endif

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int mem_cnt = 0;
    logic [4:0] row_p = 5'd0;
    logic       ts_p = 1'b0;
    logic [32:0] held;

    ifmap_row_scheduler dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ts(start_ts), .start_ready(start_ready),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready),
        .mem_rd_ts(mem_rd_ts), .mem_rd_row(mem_rd_row),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .busy(busy), .exhausted(exhausted), .err_overrun(err_overrun)
`ifdef IFMAP_SCHED_STATS_EN
        , .stat_pkts(stat_pkts), .stat_stalls(stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: one outstanding read, answered mem_lat cycles after acceptance.
    always @(negedge clk) begin
        mem_rdata_valid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                mem_rdata_valid = 1'b1;
                mem_rdata = {ts_p, 19'd0, row_p};
            end
        end
        if (mem_rd_valid === 1'b1 && mem_rd_ready && !reset && mem_cnt == 0) begin
            mem_cnt = mem_lat;
            row_p   = mem_rd_row;
            ts_p    = mem_rd_ts;
        end
    end

    function automatic logic [32:0] mk_pkt(input int dest, input logic [24:0] data);
        return {4'(dest), 4'd1, data};
    endfunction

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pkt(input string tag, input logic [32:0] exp);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (pkt_valid === 1'b1) found = 1'b1;
        end
        chk({tag, "_seen"}, {32'd0, found}, 33'd1);
        if (found) chk(tag, pkt_data, exp);
    endtask

    task automatic wait_ack(input string tag, input logic [4:0] exp);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (req_ready !== 5'd0) found = 1'b1;
        end
        chk({tag, "_seen"}, {32'd0, found}, 33'd1);
        chk(tag, {28'd0, req_ready}, {28'd0, exp});
    endtask

    task automatic do_start(input logic ts);
        @(negedge clk);
        start_valid = 1'b1;
        start_ts    = ts;
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_pkt_valid", {32'd0, pkt_valid}, 33'd0);
        chk("rst_mem_rd_valid", {32'd0, mem_rd_valid}, 33'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 33'd0);
        chk("rst_pkt_data", pkt_data, 33'd0);
        chk("rst_mem_rd_row", {28'd0, mem_rd_row}, 33'd0);
        chk("rst_exhausted", {28'd0, exhausted}, 33'd0);
        chk("rst_err", {32'd0, err_overrun}, 33'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", {32'd0, busy}, 33'd0);
        chk("idle_start_ready", {32'd0, start_ready}, 33'd1);

        // Broadcast, timestep 1
        do_start(1'b0);
        chk("b_rd_valid", {32'd0, mem_rd_valid}, 33'd1);
        chk("b_rd_row", {28'd0, mem_rd_row}, 33'd0);
        chk("b_busy", {32'd0, busy}, 33'd1);
        chk("b_rd_ts", {32'd0, mem_rd_ts}, 33'd0);
        for (int i = 0; i < 5; i++) wait_pkt("bcast_ts0", mk_pkt(5 + i, 25'(i)));
        @(negedge clk);
        chk("serve_busy", {32'd0, busy}, 33'd0);
        chk("serve_start_ready", {32'd0, start_ready}, 33'd1);

        // All PEs requesting: round robin 0..4 twice
        req_valid = 5'b11111;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) begin
                wait_ack("rr_ack", 5'(1 << k));
                if (r == 1 && k == 4) req_valid = 5'd0;
                wait_pkt("rr_pkt", mk_pkt(5 + k, 25'(5 + 5 * r + k)));
            end
        end

        // Fresh broadcast, then PE 2 runs out of rows
        do_start(1'b0);
        for (int i = 0; i < 5; i++) wait_pkt("bcast2", mk_pkt(5 + i, 25'(i)));
        req_valid = 5'b00100;
        for (int n = 0; n < 4; n++) begin
            wait_ack("pe2_ack", 5'b00100);
            chk("pe2_no_err", {32'd0, err_overrun}, 33'd0);
            wait_pkt("pe2_pkt", mk_pkt(7, 25'(7 + 5 * n)));
        end
        wait_ack("pe2_ovr_ack", 5'b00100);
        chk("pe2_err_pulse", {32'd0, err_overrun}, 33'd1);
        req_valid = 5'd0;
        chk("pe2_exhausted", {28'd0, exhausted}, {28'd0, 5'b00100});
        @(negedge clk);
        chk("pe2_err_one_cycle", {32'd0, err_overrun}, 33'd0);
        for (int i = 0; i < 5; i++) begin
            chk("pe2_no_pkt", {32'd0, pkt_valid}, 33'd0);
            @(negedge clk);
        end

        // Back-pressure: ten stalled cycles on one packet
        pkt_ready = 1'b0;
        req_valid = 5'b00001;
        wait_ack("stall_ack", 5'b00001);
        req_valid = 5'd0;
        held = mk_pkt(5, 25'd5);
        wait_pkt("stall_pkt", held);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", {32'd0, pkt_valid}, 33'd1);
            chk("stall_data", pkt_data, held);
        end
        @(negedge clk);
        chk("stall_valid_end", {32'd0, pkt_valid}, 33'd1);
`ifdef IFMAP_SCHED_STATS_EN
        chk("stat_stalls", {17'd0, stat_stalls}, 33'd10);
        chk("stat_pkts", {17'd0, stat_pkts}, 33'd9);
`endif
        pkt_ready = 1'b1;

        // Start beats a same-cycle request in SERVE
        @(negedge clk);
        start_valid = 1'b1;
        start_ts    = 1'b1;
        req_valid   = 5'b00001;
        @(negedge clk);
        start_valid = 1'b0;
        req_valid   = 5'd0;
        chk("sw_req_ready", {28'd0, req_ready}, 33'd0);
        chk("sw_rd_ts", {32'd0, mem_rd_ts}, 33'd1);
        chk("sw_rd_valid", {32'd0, mem_rd_valid}, 33'd1);
        chk("sw_rd_row", {28'd0, mem_rd_row}, 33'd0);
        chk("sw_exhausted", {28'd0, exhausted}, 33'd0);
        for (int i = 0; i < 5; i++) wait_pkt("bcast_ts1", mk_pkt(5 + i, {1'b1, 19'd0, 5'(i)}));

        // Reset while waiting for read data; late response is ignored
        mem_lat = 4;
        req_valid = 5'b00010;
        wait_ack("rw_ack", 5'b00010);
        req_valid = 5'd0;
        @(negedge clk);
        chk("rw_in_wait_busy", {32'd0, busy}, 33'd1);
        chk("rw_in_wait_rd", {32'd0, mem_rd_valid}, 33'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rw_busy", {32'd0, busy}, 33'd0);
        chk("rw_pkt_data", pkt_data, 33'd0);
        chk("rw_rd_ts", {32'd0, mem_rd_ts}, 33'd0);
`ifdef IFMAP_SCHED_STATS_EN
        chk("rw_stat_pkts", {17'd0, stat_pkts}, 33'd0);
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rw_no_pkt", {32'd0, pkt_valid}, 33'd0);
            chk("rw_idle", {32'd0, busy}, 33'd0);
        end
        chk("rw_start_ready", {32'd0, start_ready}, 33'd1);
        chk("rw_exhausted", {28'd0, exhausted}, 33'd0);
        chk("rw_rd_row", {28'd0, mem_rd_row}, 33'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
